// File: rtl/fp_unpack_pkg.sv
// Shared definitions for the floating-point unpacker: class codes and
// width/bias helpers derived from the exponent and mantissa field widths.
package fp_unpack_pkg;

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUB  = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_QNAN = 3'd4;
    localparam logic [2:0] CLS_SNAN = 3'd5;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Width able to hold a leading-zero count of 0..mant_w inclusive.
    function automatic int lzw(input int mant_w);
        return $clog2(mant_w + 1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
    parameter int WIDTH = 23,
    parameter int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [OUT_W-1:0] count
);

    // NOTE: blocking assignments in always_comb; later loop iterations
    // overwrite earlier ones, so the highest set bit decides the count.
    always_comb begin
        count = OUT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                count = OUT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_unpacker_pipe.sv
// Multi-lane floating-point unpacker: stage 1 splits and classifies each
// lane, stage 2 normalises subnormals and forms the unbiased exponent.
module fp_unpacker_pipe
    import fp_unpack_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int LANES  = 4,
    parameter int FTZ    = 0,
    localparam int LZW   = lzw(MANT_W)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [LANES*(1+EXP_W+MANT_W)-1:0] in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES-1:0]                  out_sign,
    output logic [LANES*(EXP_W+2)-1:0]        out_exp,
    output logic [LANES*(MANT_W+1)-1:0]       out_mant,
    output logic [LANES*3-1:0]                out_cls,
    output logic [LANES*LZW-1:0]              out_lzc,
    output logic                              out_any_nan
);

    localparam int W    = 1 + EXP_W + MANT_W;
    localparam int XW   = EXP_W + 2;
    localparam int MW   = MANT_W + 1;
    localparam int BIAS = fp_bias(EXP_W);

    localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0] SUB_BASE = XW'(-BIAS);

    logic s1_valid, s2_valid;
    logic adv1, adv2, take;
    logic [LANES-1:0] s1_nan;

    // Each stage advances when it is empty or the stage after it moves.
    assign adv2      = !s2_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign take      = in_valid && adv1;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (adv1) s1_valid <= in_valid;
            if (adv2) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_any_nan <= 1'b0;
        end else if (adv2 && s1_valid) begin
            out_any_nan <= |s1_nan;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic              sign_f;
        logic [EXP_W-1:0]  exp_f;
        logic [MANT_W-1:0] man_f;
        logic [LZW-1:0]    lz_c;
        logic [2:0]        cls_c;

        logic              s1_sign;
        logic [EXP_W-1:0]  s1_exp;
        logic [MANT_W-1:0] s1_man;
        logic [2:0]        s1_cls;
        logic [LZW-1:0]    s1_lz;

        logic signed [XW-1:0] exp_n;
        logic [MW-1:0]        mant_n;
        logic [LZW-1:0]       lzc_n;

        logic              s2_sign;
        logic [XW-1:0]     s2_exp;
        logic [MW-1:0]     s2_mant;
        logic [2:0]        s2_cls;
        logic [LZW-1:0]    s2_lzc;

        assign sign_f = in_data[i*W + W - 1];
        assign exp_f  = in_data[i*W + MANT_W +: EXP_W];
        assign man_f  = in_data[i*W +: MANT_W];

        fp_lzc #(.WIDTH(MANT_W), .OUT_W(LZW)) u_lzc (
            .din   (man_f),
            .count (lz_c)
        );

        always_comb begin
            cls_c = CLS_NORM;
            if (exp_f == '0) begin
                cls_c = (man_f == '0 || FTZ != 0) ? CLS_ZERO : CLS_SUB;
            end else if (exp_f == '1) begin
                if (man_f == '0)          cls_c = CLS_INF;
                else if (man_f[MANT_W-1]) cls_c = CLS_QNAN;
                else                      cls_c = CLS_SNAN;
            end
        end

        // NOTE: data registers are cleared on reset too, so a discarded
        // in-flight beat can never leak onto the outputs afterwards.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_sign <= 1'b0;
                s1_exp  <= '0;
                s1_man  <= '0;
                s1_cls  <= CLS_ZERO;
                s1_lz   <= '0;
            end else if (take) begin
                s1_sign <= sign_f;
                s1_exp  <= exp_f;
                s1_man  <= man_f;
                s1_cls  <= cls_c;
                s1_lz   <= lz_c;
            end
        end

        assign s1_nan[i] = (s1_cls == CLS_QNAN) || (s1_cls == CLS_SNAN);

        // Subnormal: shifting by lz+1 puts the leading one in the hidden
        // bit, and 1 - BIAS - (lz+1) collapses to -BIAS - lz.
        always_comb begin
            exp_n  = '0;
            mant_n = '0;
            lzc_n  = '0;
            case (s1_cls)
                CLS_NORM: begin
                    exp_n  = $signed({2'b00, s1_exp}) - BIAS_X;
                    mant_n = {1'b1, s1_man};
                end
                CLS_SUB: begin
                    exp_n  = SUB_BASE - $signed(XW'(s1_lz));
                    mant_n = {1'b0, s1_man} << (s1_lz + LZW'(1));
                    lzc_n  = s1_lz;
                end
                CLS_INF, CLS_QNAN, CLS_SNAN: begin
                    mant_n = {1'b0, s1_man};
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_sign <= 1'b0;
                s2_exp  <= '0;
                s2_mant <= '0;
                s2_cls  <= CLS_ZERO;
                s2_lzc  <= '0;
            end else if (adv2 && s1_valid) begin
                s2_sign <= s1_sign;
                s2_exp  <= exp_n;
                s2_mant <= mant_n;
                s2_cls  <= s1_cls;
                s2_lzc  <= lzc_n;
            end
        end

        assign out_sign[i]             = s2_sign;
        assign out_exp[i*XW +: XW]     = s2_exp;
        assign out_mant[i*MW +: MW]    = s2_mant;
        assign out_cls[i*3 +: 3]       = s2_cls;
        assign out_lzc[i*LZW +: LZW]   = s2_lzc;
    end

endmodule
